line_clear_sequencer: RTL

- Post-lock board controller.
- After the game logic commits a landed piece into the board row memory, this block takes ownership of that memory. It scans every row bottom-to-top, removes full rows, shifts the remaining rows down, and zero-fills the top.
- It stalls piece motion while busy and reports the lines cleared per lock and cumulatively, for scoring and display.

---
 rtl/board_pkg.sv | 28 ++
 rtl/line_clear_sequencer_if.sv | 29 ++
 rtl/line_clear_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, row/address types and the line-clear FSM state encoding.
// Also holds the saturating lines counter helper used when a run completes.
package board_pkg;
  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int ROW_BITS = 16;
  localparam int ADDR_W   = $clog2(BOARD_H);
  localparam int CNT_W    = $clog2(BOARD_H + 1);

  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [ADDR_W-1:0]   row_addr_t;
  typedef logic [CNT_W-1:0]    line_cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EVAL = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } lcs_state_t;

  // Running total add that pins at all-ones instead of wrapping
  function automatic logic [15:0] sat16(input logic [15:0] total, input line_cnt_t add);
    logic [16:0] sum;
    sum = {1'b0, total} + 17'(add);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction
endpackage

// File: rtl/line_clear_sequencer_if.sv
// Game-logic handshake plus board row RAM port of the line clear sequencer.
// master is the sequencer itself (it owns the RAM while busy); slave is the game/RAM side.
interface line_clear_sequencer_if;
  import board_pkg::*;

  logic        start;
  logic        busy;
  logic        done;
  line_cnt_t   lines_cleared;
  logic [15:0] lines_total;
  logic        rd_en;
  row_addr_t   rd_addr;
  row_t        rd_data;
  logic        wr_en;
  row_addr_t   wr_addr;
  row_t        wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, lines_cleared, lines_total,
           rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, lines_cleared, lines_total,
           rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/line_clear_sequencer.sv
// Post-lock board compactor: scans rows bottom-to-top, drops full rows, shifts the rest
// down and zero-fills the top, then reports lines cleared for this lock and in total.
module line_clear_sequencer
  import board_pkg::*;
(
  input  logic                   frame_clk,
  input  logic                   Reset,
  line_clear_sequencer_if.master bus
);

  lcs_state_t  state_r;
  row_addr_t   r_r;
  logic [ADDR_W:0] w_r;
  line_cnt_t   cnt_r;
  logic        busy_r;
  logic        done_r;
  line_cnt_t   lines_cleared_r;
  logic [15:0] lines_total_r;
  logic        rd_en_r;
  row_addr_t   rd_addr_r;

  logic        full_s;
  line_cnt_t   cnt_next_s;
  logic        wr_en_s;
  row_addr_t   wr_addr_s;
  row_t        wr_data_s;

  localparam logic [ADDR_W:0] W_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam row_addr_t       BOTTOM = row_addr_t'(BOARD_H - 1);

  // Fullness of the row returned by the RAM and the line count it implies
  always_comb begin
    full_s = &bus.rd_data[BOARD_W-1:0];
    if (full_s) begin
      cnt_next_s = cnt_r + line_cnt_t'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Write port follows the state directly: the read data arrives in EVAL and must be
  // written back in that same cycle to keep one RAM access per cycle at two cycles per row.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    case (state_r)
      EVAL: begin
        if (!full_s && (w_r != {1'b0, r_r})) begin
          wr_en_s   = 1'b1;
          wr_addr_s = w_r[ADDR_W-1:0];
          wr_data_s = bus.rd_data;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      FILL: begin
        wr_en_s   = 1'b1;
        wr_addr_s = w_r[ADDR_W-1:0];
        wr_data_s = '0;
      end
      default: begin
        wr_en_s   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, read strobe and line counters
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_r         <= IDLE;
      r_r             <= '0;
      w_r             <= '0;
      cnt_r           <= '0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      lines_cleared_r <= '0;
      lines_total_r   <= 16'h0000;
      rd_en_r         <= 1'b0;
      rd_addr_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            r_r             <= BOTTOM;
            w_r             <= {1'b0, BOTTOM};
            cnt_r           <= '0;
            lines_cleared_r <= '0;
            busy_r          <= 1'b1;
            rd_en_r         <= 1'b1;
            rd_addr_r       <= BOTTOM;
            state_r         <= RD;
          end else begin
            busy_r          <= 1'b0;
          end
        end
        RD: begin
          rd_en_r <= 1'b0;
          state_r <= EVAL;
        end
        EVAL: begin
          cnt_r <= cnt_next_s;
          if (!full_s) begin
            w_r <= w_r - W_ONE;
          end else begin
            w_r <= w_r;
          end
          if (r_r == '0) begin
            if (cnt_next_s != '0) begin
              state_r <= FILL;
            end else begin
              done_r          <= 1'b1;
              lines_cleared_r <= cnt_next_s;
              lines_total_r   <= sat16(lines_total_r, cnt_next_s);
              state_r         <= DONE;
            end
          end else begin
            r_r       <= r_r - row_addr_t'(1);
            rd_en_r   <= 1'b1;
            rd_addr_r <= r_r - row_addr_t'(1);
            state_r   <= RD;
          end
        end
        FILL: begin
          w_r <= w_r - W_ONE;
          if (w_r == '0) begin
            done_r          <= 1'b1;
            lines_cleared_r <= cnt_r;
            lines_total_r   <= sat16(lines_total_r, cnt_r);
            state_r         <= DONE;
          end else begin
            state_r         <= FILL;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.lines_cleared = lines_cleared_r;
  assign bus.lines_total   = lines_total_r;
  assign bus.rd_en         = rd_en_r;
  assign bus.rd_addr       = rd_addr_r;
  assign bus.wr_en         = wr_en_s;
  assign bus.wr_addr       = wr_addr_s;
  assign bus.wr_data       = wr_data_s;

endmodule
